// File: rtl/dma_request_conditioner.sv
// DMA request front end: DREQ synchronisers, sense polarity, mask/software-request registers, registered reqOut/HRQ.
// Optional build macro DMA_REQ_LATCH_EN turns hardware requests into edge-latched pending bits cleared by DACK or TC.
module dma_request_conditioner #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic [NUM_CH-1:0]         DREQ,
    input  logic                      dreqSense,
    input  logic                      controllerDisable,
    input  logic                      maskWrEn,
    input  logic [NUM_CH-1:0]         maskWrData,
    input  logic                      maskSetClrEn,
    input  logic [$clog2(NUM_CH)-1:0] maskSetClrCh,
    input  logic                      maskSetClrBit,
    input  logic                      swReqEn,
    input  logic [$clog2(NUM_CH)-1:0] swReqCh,
    input  logic                      swReqBit,
    input  logic [NUM_CH-1:0]         autoInit,
    input  logic                      tcValid,
    input  logic [$clog2(NUM_CH)-1:0] tcCh,
    input  logic [NUM_CH-1:0]         dackActive,
    output logic [NUM_CH-1:0]         reqOut,
    output logic                      HRQ,
    output logic [NUM_CH-1:0]         maskReg,
    output logic [NUM_CH-1:0]         swReqReg
);

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic en, input logic [$clog2(NUM_CH)-1:0] ch);
        logic [NUM_CH-1:0] one_v;
        one_v = {{(NUM_CH-1){1'b0}}, 1'b1};
        return en ? (one_v << ch) : {NUM_CH{1'b0}};
    endfunction

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] sw_q, sw_d;
    logic [NUM_CH-1:0] req_q, req_d;
    logic              hrq_q, hrq_d;

    logic [NUM_CH-1:0] req_hw_s;
    logic [NUM_CH-1:0] hw_req_s;
    logic [NUM_CH-1:0] tc_hot_s;
    logic [NUM_CH-1:0] tc_set_s;
    logic [NUM_CH-1:0] sc_hot_s;
    logic [NUM_CH-1:0] sw_hot_s;
    logic [NUM_CH-1:0] mask_wr_s;
    logic [NUM_CH-1:0] mask_sc_s;

    // Sense polarity is applied before the chain so a cleared flop always means "no request".
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= DREQ ^ {NUM_CH{dreqSense}};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign req_hw_s = sync_q[SYNC_STAGES-1];

    assign tc_hot_s  = ch_onehot(tcValid, tcCh);
    assign tc_set_s  = ch_onehot(tcValid & ~autoInit[tcCh], tcCh);
    assign sc_hot_s  = ch_onehot(maskSetClrEn, maskSetClrCh);
    assign sw_hot_s  = ch_onehot(swReqEn, swReqCh);

    // Mask writes layer in order: full write, then single-channel write, then TC auto-mask on top.
    assign mask_wr_s = maskWrEn ? maskWrData : mask_q;
    assign mask_sc_s = (mask_wr_s & ~sc_hot_s) | (sc_hot_s & {NUM_CH{maskSetClrBit}});
    assign mask_d    = mask_sc_s | tc_set_s;

    assign sw_d = ((sw_q & ~sw_hot_s) | (sw_hot_s & {NUM_CH{swReqBit}})) & ~tc_hot_s;

`ifdef DMA_REQ_LATCH_EN
    logic [NUM_CH-1:0] hw_prev_q;
    logic [NUM_CH-1:0] dack_prev_q;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] pend_clr_s;

    // Clear on the first cycle DACK is seen, or on TC; clear beats a same-cycle new edge.
    assign pend_clr_s = (dackActive & ~dack_prev_q) | tc_hot_s;
    assign pending_d  = (pending_q | (req_hw_s & ~hw_prev_q)) & ~pend_clr_s;
    assign hw_req_s   = pending_d;

    // Edge-detect history and pending request storage.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hw_prev_q   <= '0;
            dack_prev_q <= '0;
            pending_q   <= '0;
        end else begin
            hw_prev_q   <= req_hw_s;
            dack_prev_q <= dackActive;
            pending_q   <= pending_d;
        end
    end
`else
    logic dack_unused_s;

    assign dack_unused_s = ^dackActive;
    assign hw_req_s      = req_hw_s;
`endif

    assign req_d = controllerDisable ? {NUM_CH{1'b0}} : ((hw_req_s & ~mask_d) | sw_d);
    assign hrq_d = |req_d;

    // Architectural registers and registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mask_q <= {NUM_CH{1'b1}};
            sw_q   <= '0;
            req_q  <= '0;
            hrq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            sw_q   <= sw_d;
            req_q  <= req_d;
            hrq_q  <= hrq_d;
        end
    end

    assign reqOut   = req_q;
    assign HRQ      = hrq_q;
    assign maskReg  = mask_q;
    assign swReqReg = sw_q;

endmodule

// File: tb/tb_dma_request_conditioner.sv
// Scoreboard bench for dma_request_conditioner: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_dma_request_conditioner;

`ifdef DMA_REQ_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] DREQ;
    logic       dreqSense, controllerDisable;
    logic       maskWrEn;
    logic [3:0] maskWrData;
    logic       maskSetClrEn;
    logic [1:0] maskSetClrCh;
    logic       maskSetClrBit;
    logic       swReqEn;
    logic [1:0] swReqCh;
    logic       swReqBit;
    logic [3:0] autoInit;
    logic       tcValid;
    logic [1:0] tcCh;
    logic [3:0] dackActive;
    logic [3:0] reqOut, maskReg, swReqReg;
    logic       HRQ;

    dma_request_conditioner dut (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .dreqSense(dreqSense),
        .controllerDisable(controllerDisable), .maskWrEn(maskWrEn), .maskWrData(maskWrData),
        .maskSetClrEn(maskSetClrEn), .maskSetClrCh(maskSetClrCh), .maskSetClrBit(maskSetClrBit),
        .swReqEn(swReqEn), .swReqCh(swReqCh), .swReqBit(swReqBit), .autoInit(autoInit),
        .tcValid(tcValid), .tcCh(tcCh), .dackActive(dackActive), .reqOut(reqOut), .HRQ(HRQ),
        .maskReg(maskReg), .swReqReg(swReqReg)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         at;
        string      name;
        logic [3:0] req;
        logic       hrq;
        logic [3:0] mask;
        logic [3:0] sw;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: compare every expectation due at this cycle.
    always @(negedge CLK) begin
        exp_t e;
        while (sb.size() != 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.at != cyc || reqOut !== e.req || HRQ !== e.hrq || maskReg !== e.mask || swReqReg !== e.sw) begin
                errors++;
                $display("FAIL %s @cyc%0d: got reqOut=%b HRQ=%b maskReg=%b swReqReg=%b, expected %b %b %b %b (due cyc%0d)",
                         e.name, cyc, reqOut, HRQ, maskReg, swReqReg, e.req, e.hrq, e.mask, e.sw, e.at);
            end
        end
    end

    task automatic expect_at(input string nm, input int dly, input logic [3:0] r, input logic h,
                             input logic [3:0] m, input logic [3:0] s);
        exp_t e;
        e.at = cyc + dly; e.name = nm; e.req = r; e.hrq = h; e.mask = m; e.sw = s;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        exp_t left;
        RESET_N = 1'b0; DREQ = 4'b1111; dreqSense = 1'b0; controllerDisable = 1'b0;
        maskWrEn = 1'b0; maskWrData = 4'b0000; maskSetClrEn = 1'b0; maskSetClrCh = 2'd0;
        maskSetClrBit = 1'b0; swReqEn = 1'b0; swReqCh = 2'd0; swReqBit = 1'b0;
        autoInit = 4'b0000; tcValid = 1'b0; tcCh = 2'd0; dackActive = 4'b0000;
        step(3);
        RESET_N = 1'b1;
        checks++;
        if (maskReg !== 4'b1111 || reqOut !== 4'b0000 || HRQ !== 1'b0) begin
            errors++;
            $display("FAIL reset_direct: maskReg=%b reqOut=%b HRQ=%b", maskReg, reqOut, HRQ);
        end
        expect_at("reset", 0, 4'b0000, 1'b0, 4'b1111, 4'b0000);
        step(4);
        expect_at("masked_all", 0, 4'b0000, 1'b0, 4'b1111, 4'b0000);
        DREQ = 4'b0000;
        step(3);
        dackActive = 4'b1111; step(1); dackActive = 4'b0000;

        maskWrEn = 1'b1; maskWrData = 4'b0000;
        expect_at("mask_wr", 1, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        step(1); maskWrEn = 1'b0;

        DREQ = 4'b0100;
        expect_at("dreq_early", 2, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        expect_at("dreq_rise", 3, 4'b0100, 1'b1, 4'b0000, 4'b0000);
        step(3);
        DREQ = 4'b0000;
        expect_at("dreq_hold", 2, 4'b0100, 1'b1, 4'b0000, 4'b0000);
        expect_at("dreq_drop", 3, LATCH ? 4'b0100 : 4'b0000, LATCH, 4'b0000, 4'b0000);
        step(3);
        dackActive = 4'b1111;
        expect_at("dack_clr", 1, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        step(1); dackActive = 4'b0000;

        dreqSense = 1'b1; DREQ = 4'b1110;
        expect_at("sense_low", 3, 4'b0001, 1'b1, 4'b0000, 4'b0000);
        step(3);
        dreqSense = 1'b0; DREQ = 4'b0000;
        expect_at("sense_off", 3, LATCH ? 4'b0001 : 4'b0000, LATCH, 4'b0000, 4'b0000);
        step(3);
        dackActive = 4'b1111;
        expect_at("dack_clr2", 1, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        step(1); dackActive = 4'b0000;

        maskSetClrEn = 1'b1; maskSetClrCh = 2'd1; maskSetClrBit = 1'b1;
        expect_at("mask_set1", 1, 4'b0000, 1'b0, 4'b0010, 4'b0000);
        step(1); maskSetClrEn = 1'b0;
        swReqEn = 1'b1; swReqCh = 2'd1; swReqBit = 1'b1;
        expect_at("sw_masked", 1, 4'b0010, 1'b1, 4'b0010, 4'b0010);
        step(1); swReqEn = 1'b0;
        maskSetClrEn = 1'b1; maskSetClrCh = 2'd1; maskSetClrBit = 1'b0;
        expect_at("mask_clr1", 1, 4'b0010, 1'b1, 4'b0000, 4'b0010);
        step(1); maskSetClrEn = 1'b0;
        tcValid = 1'b1; tcCh = 2'd1;
        expect_at("tc_ch1", 1, 4'b0000, 1'b0, 4'b0010, 4'b0000);
        step(1); tcValid = 1'b0;

        autoInit = 4'b0100; swReqEn = 1'b1; swReqCh = 2'd2; swReqBit = 1'b1; tcValid = 1'b1; tcCh = 2'd2;
        expect_at("tc_vs_sw", 1, 4'b0000, 1'b0, 4'b0010, 4'b0000);
        step(1); swReqEn = 1'b0; tcValid = 1'b0; autoInit = 4'b0000;

        maskWrEn = 1'b1; maskWrData = 4'b0000;
        maskSetClrEn = 1'b1; maskSetClrCh = 2'd0; maskSetClrBit = 1'b1;
        tcValid = 1'b1; tcCh = 2'd3;
        expect_at("mask_order", 1, 4'b0000, 1'b0, 4'b1001, 4'b0000);
        step(1); maskWrEn = 1'b0; maskSetClrEn = 1'b0; tcValid = 1'b0;

        controllerDisable = 1'b1; swReqEn = 1'b1; swReqCh = 2'd3; swReqBit = 1'b1;
        expect_at("disable", 1, 4'b0000, 1'b0, 4'b1001, 4'b1000);
        step(1); swReqEn = 1'b0; controllerDisable = 1'b0;
        expect_at("enable", 1, 4'b1000, 1'b1, 4'b1001, 4'b1000);
        step(1);
        swReqEn = 1'b1; swReqCh = 2'd3; swReqBit = 1'b0;
        expect_at("sw_clr", 1, 4'b0000, 1'b0, 4'b1001, 4'b0000);
        step(1); swReqEn = 1'b0;

        swReqEn = 1'b1; swReqCh = 2'd0; swReqBit = 1'b1;
        expect_at("pre_reset", 1, 4'b0001, 1'b1, 4'b1001, 4'b0001);
        step(1); swReqEn = 1'b0;
        checks++;
        if (reqOut !== 4'b0001) begin
            errors++;
            $display("FAIL pre_reset_direct: reqOut=%b", reqOut);
        end
        step(1);
        RESET_N = 1'b0;
        #1;
        checks++;
        if (reqOut !== 4'b0000 || HRQ !== 1'b0 || swReqReg !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset_direct: reqOut=%b HRQ=%b swReqReg=%b", reqOut, HRQ, swReqReg);
        end
        expect_at("async_reset", 0, 4'b0000, 1'b0, 4'b1111, 4'b0000);
        step(1);
        RESET_N = 1'b1;
        step(1);

        maskWrEn = 1'b1; maskWrData = 4'b0000;
        expect_at("mask_wr2", 1, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        step(1); maskWrEn = 1'b0;
        DREQ = 4'b0001;
        expect_at("pulse", 3, 4'b0001, 1'b1, 4'b0000, 4'b0000);
        step(1); DREQ = 4'b0000;
        expect_at("pulse_after", 3, LATCH ? 4'b0001 : 4'b0000, LATCH, 4'b0000, 4'b0000);
        step(5);
        expect_at("pulse_held", 0, LATCH ? 4'b0001 : 4'b0000, LATCH, 4'b0000, 4'b0000);
        dackActive = 4'b0001;
        expect_at("dack_release", 1, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        step(1); dackActive = 4'b0000;

        for (int i = 0; i < 10 && sb.size() != 0; i++) step(1);
        while (sb.size() != 0) begin
            left = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never checked, due cyc%0d, now cyc%0d", left.name, left.at, cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
